exec_sequencer: RTL and testbench

- Multi-cycle fetch/execute sequencer for the 8-bit accumulator CPU datapath: program counter, register file, accumulator, ALU, LED register and switch input.
- Latches the instruction word presented by program memory and issues one-cycle datapath strobes: register write, accumulator store, LED store, write-data select, ALU function and PC increment.
- Provides a debounced operator handshake on Sw8 (wait-for-press/release), a halt instruction and a Run gate for single-stepping.

---
 rtl/exec_sequencer.sv | 155 +++++++++++++++
 tb/tb_exec_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU: latches the program word, issues
// one-cycle datapath strobes, and runs the debounced Sw8 wait handshake plus halt.
`timescale 1ns/1ps

module exec_sequencer #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [2:0] i_opcode,
    input  logic       i_cond,
    input  logic       i_sw8,
    input  logic       i_run,
    output logic       o_pc_inc,
    output logic       o_reg_we,
    output logic       o_wdata_sel,
    output logic       o_acc_store,
    output logic       o_led_store,
    output logic [1:0] o_alu_op,
    output logic       o_halted,
    output logic       o_waiting
);

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StWaitPress,
        StWaitRelease,
        StHalt
    } state_e;

    localparam logic [7:0] DbLimit = 8'(DEBOUNCE);

    state_e     r_state;
    logic [3:0] r_ir;
    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_cnt;

    logic [2:0] w_op;
    logic       w_in_wait;
    logic       w_await;
    logic       w_match;
    logic       w_hit;

    assign w_op      = r_ir[3:1];
    assign w_in_wait = (r_state == StWaitPress) || (r_state == StWaitRelease);
    assign w_await   = (r_state == StWaitPress);
    assign w_match   = (r_sync2 == w_await);
    // Recognition happens once the counter has actually reached the limit.
    assign w_hit     = w_in_wait && (r_cnt == DbLimit);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sw8;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= 8'd0;
        end else if (!w_in_wait || w_hit || !w_match) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != DbLimit) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StFetch;
            r_ir    <= 4'd0;
        end else begin
            case (r_state)
                StFetch: begin
                    if (i_run) begin
                        r_ir    <= {i_opcode, i_cond};
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (w_op == 3'b111) begin
                        r_state <= r_ir[0] ? StWaitPress : StHalt;
                    end else begin
                        r_state <= StFetch;
                    end
                end
                StWaitPress: begin
                    if (w_hit) begin
                        r_state <= StWaitRelease;
                    end
                end
                StWaitRelease: begin
                    if (w_hit) begin
                        r_state <= StFetch;
                    end
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, so reset drops them immediately.
    always_comb begin
        o_pc_inc    = 1'b0;
        o_reg_we    = 1'b0;
        o_wdata_sel = 1'b0;
        o_acc_store = 1'b0;
        o_led_store = 1'b0;
        o_alu_op    = 2'b00;
        o_halted    = (r_state == StHalt);
        o_waiting   = w_in_wait;
        if (r_state == StExec) begin
            o_pc_inc = (w_op != 3'b111);
            case (w_op)
                3'b001: begin
                    o_acc_store = 1'b1;
                    o_alu_op    = 2'b00;
                end
                3'b010: begin
                    o_acc_store = 1'b1;
                    o_alu_op    = 2'b01;
                end
                3'b011: begin
                    o_acc_store = 1'b1;
                    o_alu_op    = 2'b10;
                end
                3'b100: begin
                    o_reg_we = 1'b1;
                end
                3'b101: begin
                    o_reg_we    = 1'b1;
                    o_wdata_sel = 1'b1;
                end
                3'b110: begin
                    o_led_store = 1'b1;
                end
                default: begin
                end
            endcase
        end else if (r_state == StWaitRelease) begin
            o_pc_inc = w_hit;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed program words push expected strobe sets,
// a negedge monitor pops and compares whenever any strobe is presented.
`timescale 1ns/1ps

module tb_exec_sequencer;

    typedef logic [6:0] outv_t; // {pc_inc, reg_we, wdata_sel, acc_store, led_store, alu_op}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] op = 3'b000;
    logic       cond = 1'b0;
    logic       sw8 = 1'b0;
    logic       run = 1'b0;
    logic       pc_inc, reg_we, wdata_sel, acc_store, led_store, halted, waiting;
    logic [1:0] alu_op;
    outv_t      w_out;

    int    n_checks = 0;
    int    n_errors = 0;
    outv_t exp_q[$];
    outv_t mon_exp;

    localparam outv_t ExpNop  = 7'b1000000;
    localparam outv_t ExpLda  = 7'b1001000;
    localparam outv_t ExpAdd  = 7'b1001001;
    localparam outv_t ExpSub  = 7'b1001010;
    localparam outv_t ExpSta  = 7'b1100000;
    localparam outv_t ExpInsw = 7'b1110000;
    localparam outv_t ExpOut  = 7'b1000100;

    exec_sequencer #(.DEBOUNCE(4)) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_opcode   (op),
        .i_cond     (cond),
        .i_sw8      (sw8),
        .i_run      (run),
        .o_pc_inc   (pc_inc),
        .o_reg_we   (reg_we),
        .o_wdata_sel(wdata_sel),
        .o_acc_store(acc_store),
        .o_led_store(led_store),
        .o_alu_op   (alu_op),
        .o_halted   (halted),
        .o_waiting  (waiting)
    );

    assign w_out = {pc_inc, reg_we, wdata_sel, acc_store, led_store, alu_op};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Precondition: DUT stalled in FETCH with run=0; returns in the same condition.
    task automatic exec_instr(input logic [2:0] o, input logic c, input outv_t e);
        op   = o;
        cond = c;
        run  = 1'b1;
        exp_q.push_back(e);
        tick();
        run = 1'b0;
        tick();
    endtask

    task automatic release_phase();
        sw8 = 1'b0;
        exp_q.push_back(ExpNop);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("release_pcinc_timing", {31'b0, pc_inc}, {31'b0, (i == 6)});
            check("release_waiting", {31'b0, waiting}, 32'd1);
        end
        tick();
        check("after_release_fetch", {30'b0, waiting, pc_inc}, 32'd0);
    endtask

    task automatic press_release();
        sw8 = 1'b1;
        repeat (6) begin
            tick();
            check("press_waiting", {31'b0, waiting}, 32'd1);
        end
        release_phase();
    endtask

    task automatic enter_wait();
        op   = 3'b111;
        cond = 1'b1;
        run  = 1'b1;
        tick();
        check("wait_exec_no_pcinc", {30'b0, waiting, pc_inc}, 32'd0);
        run = 1'b0;
        tick();
        check("wait_entered", {31'b0, waiting}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("inv_one_store", {31'b0, ($countones({reg_we, acc_store, led_store}) <= 1)},
                  32'd1);
            check("inv_wsel_needs_we", {31'b0, (!wdata_sel || reg_we)}, 32'd1);
            check("inv_wait_halt_excl", {31'b0, !(waiting && halted)}, 32'd1);
            if (pc_inc || reg_we || acc_store || led_store) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {25'b0, w_out}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("strobe_set", {25'b0, w_out}, {25'b0, mon_exp});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ops[6];
        outv_t      exps[6];
        ops  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        exps = '{ExpLda, ExpAdd, ExpSub, ExpSta, ExpInsw, ExpOut};

        // Reset and free-running NOPs.
        run = 1'b1;
        repeat (3) begin
            tick();
            check("reset_outputs", {23'b0, w_out, halted, waiting}, 32'd0);
        end
        repeat (3) exp_q.push_back(ExpNop);
        rst_n = 1'b1;
        #1;
        check("cycle1_idle", {23'b0, w_out, halted, waiting}, 32'd0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            check("nop_pcinc_cycle", {31'b0, pc_inc}, {31'b0, (c % 2 == 0)});
            if (c == 6) run = 1'b0;
        end
        tick();

        // Each datapath instruction.
        for (int i = 0; i < 6; i++) begin
            exec_instr(ops[i], 1'(i), exps[i]);
        end

        // Stall with changing words; the Run=1 word is the one executed.
        for (int i = 0; i < 10; i++) begin
            op   = 3'(i + 1);
            cond = ~cond;
            tick();
            check("stall_no_strobe", {28'b0, pc_inc, reg_we, acc_store, led_store}, 32'd0);
        end
        exec_instr(3'b110, 1'b0, ExpOut);

        // WAIT with a short glitch, then a proper press/release.
        enter_wait();
        sw8 = 1'b1;
        repeat (3) tick();
        sw8 = 1'b0;
        repeat (8) begin
            tick();
            check("glitch_ignored", {30'b0, waiting, pc_inc}, 32'd2);
        end
        press_release();

        // Reset in WAIT_RELEASE, then a fresh wait with Sw8 already held high.
        enter_wait();
        sw8 = 1'b1;
        repeat (7) tick();
        check("in_wait_release", {31'b0, waiting}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_wait", {23'b0, w_out, halted, waiting}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_reset_idle", {23'b0, w_out, halted, waiting}, 32'd0);
        tick();
        enter_wait();
        repeat (10) begin
            tick();
            check("held_high_needs_release", {30'b0, waiting, pc_inc}, 32'd2);
        end
        release_phase();

        // HALT ignores Run and Sw8.
        op   = 3'b111;
        cond = 1'b0;
        run  = 1'b1;
        tick();
        check("halt_exec_no_pcinc", {30'b0, halted, pc_inc}, 32'd0);
        tick();
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) sw8 = ~sw8;
            tick();
            check("halt_hold", {29'b0, halted, waiting, pc_inc}, 32'd4);
        end
        rst_n = 1'b0;
        run   = 1'b0;
        sw8   = 1'b0;
        #1;
        check("halt_reset", {31'b0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("halt_cleared", {23'b0, w_out, halted, waiting}, 32'd0);
        exec_instr(3'b010, 1'b0, ExpAdd);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
